// File: rtl/itw_pkg.sv
// Shared constants and helpers for the inverse inter-stage twiddle of a 16-point radix-4 FFT.
// Twiddle values are Q1.15 cos/sin of 2*pi*k/16 for the k values that can occur.
package itw_pkg;

    localparam int DW = 16;

    localparam logic signed [15:0] COS_22_5 = 16'sd30274;
    localparam logic signed [15:0] SIN_22_5 = 16'sd12540;
    localparam logic signed [15:0] COS_45   = 16'sd23170;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_ROT90  = 2'd1,
        MODE_CMUL   = 2'd2
    } mode_e;

    function automatic logic [3:0] k_of(input logic [3:0] n);
        return {2'b00, n[3:2]} * {2'b00, n[1:0]};
    endfunction

    function automatic mode_e mode_of(input logic [3:0] k);
        case (k)
            4'd0:    return MODE_BYPASS;
            4'd4:    return MODE_ROT90;
            default: return MODE_CMUL;
        endcase
    endfunction

    // Real part c of conj(W16^k) = c + jd.
    function automatic logic signed [15:0] tw_c(input logic [3:0] k);
        case (k)
            4'd1:    return COS_22_5;
            4'd2:    return COS_45;
            4'd3:    return SIN_22_5;
            4'd6:    return -COS_45;
            4'd9:    return -COS_22_5;
            default: return 16'sd0;
        endcase
    endfunction

    function automatic logic signed [15:0] tw_d(input logic [3:0] k);
        case (k)
            4'd1:    return SIN_22_5;
            4'd2:    return COS_45;
            4'd3:    return COS_22_5;
            4'd6:    return COS_45;
            4'd9:    return -SIN_22_5;
            default: return 16'sd0;
        endcase
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [32:0] v);
        if (v > 33'sd32767)
            return 16'sh7fff;
        if (v < -33'sd32768)
            return 16'sh8000;
        return v[15:0];
    endfunction

    // The only negation that overflows is -(-32768); clamp it to full scale.
    function automatic logic signed [15:0] neg_sat(input logic signed [15:0] v);
        if (v == 16'sh8000)
            return 16'sh7fff;
        return -v;
    endfunction

endpackage

// File: rtl/itw_cmul.sv
// Two-stage Q1.15 complex multiply (a+jb)*(c+jd): products, then sum, round-half-up,
// arithmetic shift by 15 and saturation. Both stages advance only when en is high.
module itw_cmul
    import itw_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    input  logic signed [DW-1:0] c,
    input  logic signed [DW-1:0] d,
    output logic signed [DW-1:0] re,
    output logic signed [DW-1:0] im
);

    localparam int PW = 2 * DW;
    localparam int SW = 2 * DW + 1;

    logic signed [PW-1:0] p_ac_q, p_ac_d, p_bd_q, p_bd_d;
    logic signed [PW-1:0] p_ad_q, p_ad_d, p_bc_q, p_bc_d;
    logic signed [DW-1:0] re_q, re_d, im_q, im_d;
    logic signed [SW-1:0] sum_re, sum_im;

    always_comb begin
        p_ac_d = p_ac_q;
        p_bd_d = p_bd_q;
        p_ad_d = p_ad_q;
        p_bc_d = p_bc_q;
        re_d   = re_q;
        im_d   = im_q;
        sum_re = SW'(p_ac_q) - SW'(p_bd_q) + SW'(16384);
        sum_im = SW'(p_ad_q) + SW'(p_bc_q) + SW'(16384);
        if (en) begin
            p_ac_d = PW'(a) * PW'(c);
            p_bd_d = PW'(b) * PW'(d);
            p_ad_d = PW'(a) * PW'(d);
            p_bc_d = PW'(b) * PW'(c);
            re_d   = sat16(sum_re >>> 15);
            im_d   = sat16(sum_im >>> 15);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_ac_q <= '0;
            p_bd_q <= '0;
            p_ad_q <= '0;
            p_bc_q <= '0;
            re_q   <= '0;
            im_q   <= '0;
        end else begin
            p_ac_q <= p_ac_d;
            p_bd_q <= p_bd_d;
            p_ad_q <= p_ad_d;
            p_bc_q <= p_bc_d;
            re_q   <= re_d;
            im_q   <= im_d;
        end
    end

    assign re = re_q;
    assign im = im_q;

endmodule

// File: rtl/itwiddle_stream.sv
// Streaming inverse inter-stage twiddle: index tracking, k selection, exact bypass paths
// and a 3-stage valid/ready pipeline wrapped around itw_cmul.
module itwiddle_stream #(
    parameter int DW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_re,
    output logic signed [DW-1:0] out_im,
    output logic                 out_last,
    output logic                 frame_err
);

    import itw_pkg::*;

    logic                 enable, accept;
    logic [3:0]           idx_q, idx_d;
    logic                 frame_err_q, frame_err_d;

    logic                 s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic signed [DW-1:0] s1_re_q, s1_re_d, s1_im_q, s1_im_d;
    logic [3:0]           s1_k_q, s1_k_d;

    logic                 s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
    mode_e                s2_mode_q, s2_mode_d;
    logic signed [DW-1:0] s2_re_q, s2_re_d, s2_im_q, s2_im_d;

    logic                 s3_valid_q, s3_valid_d, s3_last_q, s3_last_d;
    mode_e                s3_mode_q, s3_mode_d;
    logic signed [DW-1:0] s3_re_q, s3_re_d, s3_im_q, s3_im_d;

    logic signed [DW-1:0] tw_re, tw_im, cm_re, cm_im;

    // The whole pipeline freezes as one unit whenever the output is held back.
    always_comb begin
        enable      = !s3_valid_q || out_ready;
        accept      = in_valid && enable;
        tw_re       = tw_c(s1_k_q);
        tw_im       = tw_d(s1_k_q);
        idx_d       = idx_q;
        frame_err_d = frame_err_q;
        s1_valid_d  = s1_valid_q;
        s1_last_d   = s1_last_q;
        s1_re_d     = s1_re_q;
        s1_im_d     = s1_im_q;
        s1_k_d      = s1_k_q;
        s2_valid_d  = s2_valid_q;
        s2_last_d   = s2_last_q;
        s2_mode_d   = s2_mode_q;
        s2_re_d     = s2_re_q;
        s2_im_d     = s2_im_q;
        s3_valid_d  = s3_valid_q;
        s3_last_d   = s3_last_q;
        s3_mode_d   = s3_mode_q;
        s3_re_d     = s3_re_q;
        s3_im_d     = s3_im_q;

        // A misplaced or missing in_last flags the frame; in_last always restarts at 0.
        if (accept) begin
            if (in_last != (idx_q == 4'd15))
                frame_err_d = 1'b1;
            idx_d = in_last ? 4'd0 : idx_q + 4'd1;
        end

        if (enable) begin
            s1_valid_d = accept;
            s1_last_d  = (idx_q == 4'd15);
            s1_re_d    = in_re;
            s1_im_d    = in_im;
            s1_k_d     = k_of(idx_q);

            s2_valid_d = s1_valid_q;
            s2_last_d  = s1_last_q;
            s2_mode_d  = mode_of(s1_k_q);
            if (mode_of(s1_k_q) == MODE_ROT90) begin
                s2_re_d = neg_sat(s1_im_q);
                s2_im_d = s1_re_q;
            end else begin
                s2_re_d = s1_re_q;
                s2_im_d = s1_im_q;
            end

            s3_valid_d = s2_valid_q;
            s3_last_d  = s2_last_q;
            s3_mode_d  = s2_mode_q;
            s3_re_d    = s2_re_q;
            s3_im_d    = s2_im_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q       <= '0;
            frame_err_q <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_re_q     <= '0;
            s1_im_q     <= '0;
            s1_k_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_mode_q   <= MODE_BYPASS;
            s2_re_q     <= '0;
            s2_im_q     <= '0;
            s3_valid_q  <= 1'b0;
            s3_last_q   <= 1'b0;
            s3_mode_q   <= MODE_BYPASS;
            s3_re_q     <= '0;
            s3_im_q     <= '0;
        end else begin
            idx_q       <= idx_d;
            frame_err_q <= frame_err_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_re_q     <= s1_re_d;
            s1_im_q     <= s1_im_d;
            s1_k_q      <= s1_k_d;
            s2_valid_q  <= s2_valid_d;
            s2_last_q   <= s2_last_d;
            s2_mode_q   <= s2_mode_d;
            s2_re_q     <= s2_re_d;
            s2_im_q     <= s2_im_d;
            s3_valid_q  <= s3_valid_d;
            s3_last_q   <= s3_last_d;
            s3_mode_q   <= s3_mode_d;
            s3_re_q     <= s3_re_d;
            s3_im_q     <= s3_im_d;
        end
    end

    itw_cmul u_cmul (
        .clk (clk),
        .rst (rst),
        .en  (enable),
        .a   (s1_re_q),
        .b   (s1_im_q),
        .c   (tw_re),
        .d   (tw_im),
        .re  (cm_re),
        .im  (cm_im)
    );

    assign in_ready  = enable;
    assign out_valid = s3_valid_q;
    assign out_last  = s3_last_q;
    assign frame_err = frame_err_q;
    assign out_re    = (s3_mode_q == MODE_CMUL) ? cm_re : s3_re_q;
    assign out_im    = (s3_mode_q == MODE_CMUL) ? cm_im : s3_im_q;

endmodule

// File: tb/tb_itwiddle_stream.sv
// Directed bench for itwiddle_stream: a hand-computed 16-sample frame table plus
// sequences for stalls, frame errors and mid-frame reset.
module tb_itwiddle_stream;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid, in_ready, in_last;
    logic signed [15:0] in_re, in_im;
    logic               out_valid, out_ready, out_last, frame_err;
    logic signed [15:0] out_re, out_im;

    typedef struct {
        logic signed [15:0] in_re;
        logic signed [15:0] in_im;
        logic               in_last;
        logic signed [15:0] exp_re;
        logic signed [15:0] exp_im;
        logic               exp_last;
    } vec_t;

    vec_t tbl [16];
    int   checks = 0;
    int   errors = 0;

    itwiddle_stream #(.DW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_last  (out_last),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input int a, input int b, input bit l,
                                input int er, input int ei, input bit el);
        vec_t v;
        v.in_re    = 16'(a);
        v.in_im    = 16'(b);
        v.in_last  = l;
        v.exp_re   = 16'(er);
        v.exp_im   = 16'(ei);
        v.exp_last = el;
        return v;
    endfunction

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive one sample into an idle pipeline and check result and 3-cycle latency.
    task automatic apply_stimulus(input string tag, input vec_t v);
        int waitc;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_re     = v.in_re;
        in_im     = v.in_im;
        in_last   = v.in_last;
        @(negedge clk);
        check_output({tag, "_in_ready"}, int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        waitc    = 0;
        do begin
            @(negedge clk);
            waitc++;
        end while (!out_valid && waitc < 10);
        check_output({tag, "_latency"}, waitc, 3);
        check_output({tag, "_re"}, int'(out_re), int'(v.exp_re));
        check_output({tag, "_im"}, int'(out_im), int'(v.exp_im));
        check_output({tag, "_last"}, int'(out_last), int'(v.exp_last));
    endtask

    // Stream the whole table; optionally hold out_ready low for five cycles mid-frame.
    task automatic run_stream(input string tag, input bit with_stall);
        int tx = 0;
        int rx = 0;
        for (int cyc = 0; cyc < 80 && rx < 16; cyc++) begin
            @(posedge clk); #1;
            out_ready = !(with_stall && cyc >= 8 && cyc < 13);
            if (tx < 16) begin
                in_valid = 1'b1;
                in_re    = tbl[tx].in_re;
                in_im    = tbl[tx].in_im;
                in_last  = tbl[tx].in_last;
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            @(negedge clk);
            if (!with_stall)
                check_output($sformatf("%s_valid_c%0d", tag, cyc), int'(out_valid),
                             (cyc >= 3) ? 1 : 0);
            if (!out_ready) begin
                check_output($sformatf("%s_stall_valid_c%0d", tag, cyc), int'(out_valid), 1);
                check_output($sformatf("%s_stall_in_ready_c%0d", tag, cyc), int'(in_ready), 0);
            end
            if (out_valid && rx < 16) begin
                check_output($sformatf("%s_re_%0d", tag, rx), int'(out_re), int'(tbl[rx].exp_re));
                check_output($sformatf("%s_im_%0d", tag, rx), int'(out_im), int'(tbl[rx].exp_im));
                check_output($sformatf("%s_last_%0d", tag, rx), int'(out_last), int'(tbl[rx].exp_last));
                if (out_ready)
                    rx++;
            end
            if (in_valid && in_ready)
                tx++;
        end
        check_output({tag, "_delivered"}, rx, 16);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        vec_t v;
        vec_t byp;

        tbl[0]  = mk(-32768,      5, 0, -32768,      5, 0);
        tbl[1]  = mk(  1234,  -4321, 0,   1234,  -4321, 0);
        tbl[2]  = mk( 32767, -32768, 0,  32767, -32768, 0);
        tbl[3]  = mk(     0,      7, 0,      0,      7, 0);
        tbl[4]  = mk(    -1,      1, 0,     -1,      1, 0);
        tbl[5]  = mk( 16384,      0, 0,  15137,   6270, 0);
        tbl[6]  = mk( 16384,  16384, 0,      0,  23170, 0);
        tbl[7]  = mk(     0,  16384, 0, -15137,   6270, 0);
        tbl[8]  = mk(   100,    200, 0,    100,    200, 0);
        tbl[9]  = mk(-32768, -32768, 0,      0, -32768, 0);
        tbl[10] = mk(   100, -32768, 0,  32767,    100, 0);
        tbl[11] = mk(    -1,      0, 0,      1,     -1, 0);
        tbl[12] = mk(    -5,     -6, 0,     -5,     -6, 0);
        tbl[13] = mk(     1,      0, 0,      0,      1, 0);
        tbl[14] = mk(     0,  16384, 0, -11585, -11585, 0);
        tbl[15] = mk(-32768, -32768, 1,  17734,  32767, 1);
        byp     = mk( 16384,      0, 0,  16384,      0, 0);

        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_re     = '0;
        in_im     = '0;
        out_ready = 1'b1;

        apply_reset();
        check_output("rst_out_valid", int'(out_valid), 0);
        check_output("rst_out_re", int'(out_re), 0);
        check_output("rst_out_im", int'(out_im), 0);
        check_output("rst_out_last", int'(out_last), 0);
        check_output("rst_frame_err", int'(frame_err), 0);
        check_output("rst_in_ready", int'(in_ready), 1);

        run_stream("b2b", 1'b0);
        run_stream("stall", 1'b1);
        check_output("stream_frame_err", int'(frame_err), 0);

        // in_last on index 7 must flag the frame and restart the index at 0.
        for (int i = 0; i < 8; i++) begin
            v = tbl[i];
            v.in_last = (i == 7);
            apply_stimulus($sformatf("ferr_s%0d", i), v);
        end
        check_output("ferr_set", int'(frame_err), 1);
        apply_stimulus("ferr_resync0", byp);
        apply_stimulus("ferr_resync1", byp);
        check_output("ferr_sticky", int'(frame_err), 1);

        // Reset with six samples accepted and three still in flight.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_re     = 16'sd16384;
            in_im     = 16'sd16384;
            in_last   = 1'b0;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_output("pre_rst_out_valid", int'(out_valid), 1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_output("midrst_out_valid", int'(out_valid), 0);
        check_output("midrst_out_re", int'(out_re), 0);
        check_output("midrst_frame_err", int'(frame_err), 0);
        @(negedge clk);
        rst = 1'b0;
        check_output("midrst_in_ready", int'(in_ready), 1);
        apply_stimulus("midrst_idx0", byp);
        apply_stimulus("midrst_idx1", byp);
        check_output("midrst_no_flush_out", int'(out_valid), 1);

        // A full frame whose index-15 sample lacks in_last.
        apply_reset();
        for (int i = 0; i < 15; i++)
            apply_stimulus($sformatf("nolast_s%0d", i), tbl[i]);
        check_output("nolast_err_before", int'(frame_err), 0);
        v = tbl[15];
        v.in_last = 1'b0;
        apply_stimulus("nolast_s15", v);
        check_output("nolast_err_set", int'(frame_err), 1);
        apply_stimulus("nolast_wrap0", byp);
        v = tbl[5];
        v.exp_re = v.in_re;
        v.exp_im = v.in_im;
        apply_stimulus("nolast_wrap1", v);
        check_output("nolast_err_sticky", int'(frame_err), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
